// File: rtl/tdm_mux_if.sv
// tdm_mux_if: data/handshake bundle between sample sources, the TDM mux and
// the downstream datapath.
//   in_data   : NCH packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel sample valid (source -> mux)
//   in_ready  : per-channel accept (mux -> source)
//   out_data  : selected sample (mux -> sink)
//   out_ch    : channel index of out_data
//   out_valid : out_data holds an unconsumed sample
//   out_ready : downstream accept (sink -> mux)
// master = the side driving the sources and the sink; slave = the mux.
interface tdm_mux_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/tdm_mux_seq.sv
// tdm_mux_seq: registered NCH-channel multiplexer with valid/ready on every
// input and on the output. Fixed mode (mode=0) passes channel sel; scan mode
// (mode=1) walks the enabled channels of ch_mask in ascending order, taking
// dwell+1 samples from each before moving on.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : tdm_mux_if slave (in_data/in_valid/in_ready, out_*)
//   ch_mask   : per-channel enable for scan mode
//   mode      : 0 = fixed select, 1 = auto scan
//   sel       : channel index for fixed mode
//   dwell     : samples per channel minus one in scan mode
//   scan_wrap : one-cycle pulse after the scan wraps to the lowest channel
module tdm_mux_seq #(
    parameter int WIDTH   = 16,
    parameter int NCH     = 4,
    parameter int SELW    = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    tdm_mux_if.slave           bus,
    input  logic [NCH-1:0]     ch_mask,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic               scan_wrap
);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_r, state_s;
    logic [SELW-1:0]     cur_r, cur_s;
    logic [DWELL_W-1:0]  cnt_r, cnt_s;
    logic [DWELL_W-1:0]  dwell_r, dwell_s;
    logic [WIDTH-1:0]    out_data_r;
    logic [SELW-1:0]     out_ch_r;
    logic                out_valid_r;
    logic                scan_wrap_r;

    logic [SELW-1:0]     chan_s;
    logic                active_s;
    logic                slot_free_s;
    logic                mask_cur_s;
    logic                xfer_s;
    logic                wrap_s;
    logic [NCH-1:0]      rdy_s;
    logic [WIDTH-1:0]    data_s;
    logic [SELW:0]       adv_s;
    logic [SELW-1:0]     adv_cur_s;
    logic                adv_wrap_s;

    // Index of the lowest set bit of m (0 when m is empty).
    function automatic logic [SELW-1:0] low_bit(input logic [NCH-1:0] m);
        logic [SELW-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = m[i] ? SELW'(i) : idx;
        end
        return idx;
    endfunction

    // {found, index} of the lowest set bit of m strictly above c.
    function automatic logic [SELW:0] next_bit(input logic [NCH-1:0] m,
                                               input logic [SELW-1:0] c);
        logic            found;
        logic [SELW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            found = (m[i] && (i > int'(c))) ? 1'b1 : found;
            idx   = (m[i] && (i > int'(c))) ? SELW'(i) : idx;
        end
        return {found, idx};
    endfunction

    // Next channel in ascending scan order; wraps to the lowest enabled bit.
    assign adv_s       = next_bit(ch_mask, cur_r);
    assign adv_cur_s   = adv_s[SELW] ? adv_s[SELW-1:0] : low_bit(ch_mask);
    assign adv_wrap_s  = ~adv_s[SELW];
    assign slot_free_s = ~out_valid_r | bus.out_ready;

    // Enable bit of the current scan channel (cur_r may exceed NCH-1 after fixed mode).
    always_comb begin
        mask_cur_s = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            mask_cur_s = (cur_r == SELW'(i)) ? ch_mask[i] : mask_cur_s;
        end
    end

    // Channel being offered this cycle and whether it may accept at all.
    always_comb begin
        chan_s   = cur_r;
        active_s = 1'b0;
        if (mode == 1'b0) begin
            chan_s   = sel;
            active_s = (int'(sel) < NCH);
        end else if (state_r == RUN) begin
            active_s = (ch_mask != '0) & mask_cur_s;
        end else begin
            active_s = 1'b0;
        end
    end

    // One-hot ready, held low during reset, and the matching data mux.
    always_comb begin
        rdy_s  = '0;
        data_s = '0;
        for (int i = 0; i < NCH; i++) begin
            rdy_s[i] = (chan_s == SELW'(i)) ? (slot_free_s & active_s & ~rst) : 1'b0;
            data_s   = (chan_s == SELW'(i)) ? bus.in_data[i*WIDTH +: WIDTH] : data_s;
        end
    end

    assign xfer_s       = |(rdy_s & bus.in_valid);
    assign bus.in_ready = rdy_s;

    // Scan FSM next state: channel entry, dwell counting and wrap detection.
    always_comb begin
        state_s = state_r;
        cur_s   = cur_r;
        cnt_s   = cnt_r;
        dwell_s = dwell_r;
        wrap_s  = 1'b0;
        if (mode == 1'b0) begin
            // Fixed mode parks the FSM so a return to scan restarts cleanly.
            state_s = IDLE;
            cur_s   = sel;
            cnt_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ch_mask == '0) begin
                        state_s = IDLE;
                    end else begin
                        state_s = RUN;
                        cur_s   = low_bit(ch_mask);
                        cnt_s   = '0;
                        dwell_s = dwell;
                    end
                end
                RUN: begin
                    if (ch_mask == '0) begin
                        state_s = IDLE;
                        cnt_s   = '0;
                    end else if (!mask_cur_s) begin
                        // Channel disabled under us: skip ahead, no transfer this cycle.
                        cur_s   = adv_cur_s;
                        cnt_s   = '0;
                        dwell_s = dwell;
                        wrap_s  = adv_wrap_s;
                    end else if (xfer_s) begin
                        if (cnt_r == dwell_r) begin
                            cur_s   = adv_cur_s;
                            cnt_s   = '0;
                            dwell_s = dwell;
                            wrap_s  = adv_wrap_s;
                        end else begin
                            cnt_s = cnt_r + DWELL_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // State and output registers; reset drops any pending output sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cur_r       <= '0;
            cnt_r       <= '0;
            dwell_r     <= '0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            out_valid_r <= 1'b0;
            scan_wrap_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cur_r       <= cur_s;
            cnt_r       <= cnt_s;
            dwell_r     <= dwell_s;
            scan_wrap_r <= wrap_s;
            if (xfer_s) begin
                out_data_r  <= data_s;
                out_ch_r    <= chan_s;
                out_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_valid = out_valid_r;
    assign scan_wrap     = scan_wrap_r;

endmodule

// File: tb/tb_tdm_mux_seq.sv
// Self-checking bench for tdm_mux_seq: a table of per-cycle vectors
// (inputs plus expected in_ready and registered outputs), followed by
// hand-written backpressure, mode-toggle, reset and illegal-select sequences.
module tb_tdm_mux_seq;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] ch_mask;
    logic [7:0] dwell;
    logic       scan_wrap;

    logic       mode3;
    logic [1:0] sel3;
    logic [2:0] ch_mask3;
    logic [7:0] dwell3;
    logic       scan_wrap3;

    int n_tests = 0;
    int n_fail  = 0;

    tdm_mux_if #(.WIDTH(16), .NCH(4), .SELW(2)) bus ();
    tdm_mux_if #(.WIDTH(16), .NCH(3), .SELW(2)) bus3 ();

    tdm_mux_seq #(.WIDTH(16), .NCH(4), .SELW(2), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ch_mask(ch_mask), .mode(mode),
        .sel(sel), .dwell(dwell), .scan_wrap(scan_wrap)
    );

    tdm_mux_seq #(.WIDTH(16), .NCH(3), .SELW(2), .DWELL_W(8)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .ch_mask(ch_mask3), .mode(mode3),
        .sel(sel3), .dwell(dwell3), .scan_wrap(scan_wrap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] mask;
        logic [7:0] dwell;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic       chk_data;
        logic [1:0] exp_ch;
        logic [15:0] exp_data;
        logic       exp_wrap;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic md, input logic [1:0] s,
                                input logic [3:0] msk, input logic [7:0] dw,
                                input logic ordy, input logic [3:0] erdy,
                                input logic eov, input logic cd, input logic [1:0] ech,
                                input logic [15:0] edata, input logic ewrap);
        vec_t v;
        v.rst = r; v.mode = md; v.sel = s; v.mask = msk; v.dwell = dw; v.ordy = ordy;
        v.exp_rdy = erdy; v.exp_ov = eov; v.chk_data = cd; v.exp_ch = ech;
        v.exp_data = edata; v.exp_wrap = ewrap;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Channel i of the main DUT carries base+i.
    task automatic set_data(input logic [15:0] base);
        for (int i = 0; i < 4; i++) bus.in_data[i*16 +: 16] = base + 16'(i);
    endtask

    task automatic apply(input vec_t v, input string tag);
        rst = v.rst; mode = v.mode; sel = v.sel; ch_mask = v.mask;
        dwell = v.dwell; bus.out_ready = v.ordy;
        #1;
        chk({tag, ".in_ready"}, bus.in_ready, v.exp_rdy);
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, bus.out_valid, v.exp_ov);
        chk({tag, ".scan_wrap"}, scan_wrap, v.exp_wrap);
        if (v.chk_data) begin
            chk({tag, ".out_ch"}, bus.out_ch, v.exp_ch);
            chk({tag, ".out_data"}, bus.out_data, v.exp_data);
        end
    endtask

    vec_t tbl[$];
    vec_t seq[$];

    initial begin
        logic [13:0] bp_pat;
        logic [15:0] hold;
        logic        have_hold;
        logic        took_in;
        int          k;
        int          m;

        // Reset, fixed select, scan order with dwell=1, mask edge cases.
        tbl.push_back(mk(1'b1, 1'b0, 2'd2, 4'b0000, 8'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 2'd2, 4'b0000, 8'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b0, 2'd2, 4'b0000, 8'd0, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 16'hA002, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b1011, 8'd1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 16'hA002, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b1011, 8'd1, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 16'hA000, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b1011, 8'd1, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 16'hA000, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b1011, 8'd1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 16'hA001, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b1011, 8'd1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 16'hA001, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b1011, 8'd1, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 16'hA003, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b1011, 8'd1, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 16'hA003, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b1011, 8'd1, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 16'hA000, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b1011, 8'd1, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 16'hA000, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b1011, 8'd1, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 16'hA001, 1'b0));
        // ch_mask[1] cleared mid-dwell: skip to channel 2 with no transfer.
        tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b0100, 8'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 16'hA001, 1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b0100, 8'd0, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 16'hA002, 1'b1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b0, 1'b1, 2'd2, 4'b0000, 8'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 16'hA002, 1'b0));

        rst = 1'b1; mode = 1'b0; sel = 2'd2; ch_mask = 4'b0000; dwell = 8'd0;
        bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        set_data(16'hA000);
        mode3 = 1'b0; sel3 = 2'd3; ch_mask3 = 3'b111; dwell3 = 8'd0;
        bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) bus3.in_data[i*16 +: 16] = 16'hC000 + 16'(i);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

        // Backpressure in fixed mode on channel 1 with a counting source.
        bp_pat = 14'b11101111000111;   // applied LSB first: 1,1,1,0,0,0,1,1,1,1,0,1,1,1
        k = 0; m = 0; have_hold = 1'b0; hold = 16'h0000;
        mode = 1'b0; sel = 2'd1;
        for (int c = 0; c < 14; c++) begin
            bus.out_ready = bp_pat[c];
            bus.in_data[16 +: 16] = 16'hB000 + 16'(k);
            #1;
            if (!bus.out_ready && bus.out_valid) begin
                chk($sformatf("bp%0d.stall_in_ready", c), bus.in_ready, 4'b0000);
                if (have_hold) chk($sformatf("bp%0d.hold", c), bus.out_data, hold);
                hold = bus.out_data;
                have_hold = 1'b1;
            end else begin
                have_hold = 1'b0;
            end
            took_in = bus.in_valid[1] & bus.in_ready[1];
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("bp%0d.seq", c), bus.out_data, 16'hB000 + 16'(m));
                chk($sformatf("bp%0d.ch", c), bus.out_ch, 2'd1);
                m++;
            end
            @(posedge clk);
            #1;
            if (took_in) k++;
        end
        chk("bp.total_out", m, 9);
        chk("bp.outstanding", k - m, {31'b0, bus.out_valid});
        set_data(16'hA000);

        // Mode toggle mid-dwell with a held output, then reset mid-scan.
        seq.push_back(mk(1'b0, 1'b1, 2'd1, 4'b1011, 8'd3, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0));
        seq.push_back(mk(1'b0, 1'b1, 2'd1, 4'b1011, 8'd3, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 16'hA000, 1'b0));
        seq.push_back(mk(1'b0, 1'b1, 2'd1, 4'b1011, 8'd3, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 16'hA000, 1'b0));
        seq.push_back(mk(1'b0, 1'b0, 2'd3, 4'b1011, 8'd3, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 16'hA000, 1'b0));
        seq.push_back(mk(1'b0, 1'b1, 2'd3, 4'b1011, 8'd3, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 16'hA000, 1'b0));
        for (int i = 0; i < 4; i++)
            seq.push_back(mk(1'b0, 1'b1, 2'd3, 4'b1011, 8'd3, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 16'hA000, 1'b0));
        seq.push_back(mk(1'b0, 1'b1, 2'd3, 4'b1011, 8'd3, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 16'hA001, 1'b0));
        seq.push_back(mk(1'b1, 1'b1, 2'd3, 4'b1011, 8'd3, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0));
        seq.push_back(mk(1'b0, 1'b1, 2'd3, 4'b1011, 8'd3, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0));
        seq.push_back(mk(1'b0, 1'b1, 2'd3, 4'b1011, 8'd3, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 16'hA000, 1'b0));
        for (int i = 0; i < seq.size(); i++) apply(seq[i], $sformatf("s%0d", i));

        // NCH=3 instance has held sel=3 since reset: never ready, never valid.
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("n3.%0d.in_ready", i), bus3.in_ready, 3'b000);
            chk($sformatf("n3.%0d.out_valid", i), bus3.out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        sel3 = 2'd2;
        #1;
        chk("n3.sel2.in_ready", bus3.in_ready, 3'b100);
        @(posedge clk);
        #1;
        chk("n3.sel2.out_valid", bus3.out_valid, 1'b1);
        chk("n3.sel2.out_data", bus3.out_data, 16'hC002);
        chk("n3.sel2.out_ch", bus3.out_ch, 2'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_mux_seq.md
Name: tdm_mux_seq

Overview:
- Parametrised, registered N-channel multiplexer with valid/ready handshakes on every input and on the output.
- Generalises the 16-bit two-input datapath mux to NCH channels of WIDTH bits.
- Two modes: fixed channel select, or automatic time-division scan over an enable mask with a programmable per-channel dwell.
- Feeds the modulator/decimator datapath from several sample sources.

Parameters:
- WIDTH, 16, data bits per channel
- NCH, 4, number of input channels (2..16)
- SELW, 2, channel index width; NCH must be <= 2^SELW
- DWELL_W, 8, width of the dwell-count input

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel sample valid
- in_ready  output  NCH  per-channel accept; combinational
- ch_mask  input  NCH  per-channel enable for scan mode
- mode  input  1  0 = fixed select, 1 = auto scan
- sel  input  SELW  channel index used in fixed mode
- dwell  input  DWELL_W  samples per channel in scan = dwell+1
- out_data  output  WIDTH  registered selected sample
- out_ch  output  SELW  channel index of out_data
- out_valid  output  1  out_data holds an unconsumed sample
- out_ready  input  1  downstream accept
- scan_wrap  output  1  one-cycle pulse when scan wraps past the highest enabled channel

Behaviour:
- Reset (rst=1 at clk edge):
  - cur=0, cnt=0, state=IDLE
  - out_data=0, out_ch=0, out_valid=0, scan_wrap=0
  - in_ready=0 while rst is high
- Transfers:
  - slot_free = !out_valid | out_ready.
  - in_ready[i] = slot_free & active & (i==cur); all other bits are 0.
  - An input transfer occurs on channel cur when in_valid[cur] & in_ready[cur].
  - On a transfer, next cycle: out_data = in_data[cur], out_ch = cur, out_valid = 1. Latency is 1 cycle.
  - If out_valid & out_ready and there is no new transfer, out_valid clears next cycle.
  - With continuous valid/ready, throughput is 1 sample per cycle.
  - While out_valid & !out_ready: out_data and out_ch are held stable and in_ready = 0.
- Fixed mode (mode=0):
  - cur = sel, evaluated every cycle; active = (sel < NCH).
  - If sel >= NCH, no channel is ready and no output is produced.
  - ch_mask and dwell are ignored.
- Scan mode (mode=1), FSM states IDLE, RUN:
  - IDLE:
    - If ch_mask == 0, stay in IDLE with active=0.
    - Otherwise load cur = lowest set mask bit, cnt=0, go to RUN.
  - RUN, active=1:
    - Each transfer increments cnt.
    - On the transfer where cnt == dwell: cnt=0, cur = next set mask bit above cur (ascending).
    - If no set bit exists above cur, cur = lowest set bit and scan_wrap pulses high on the following cycle.
  - A single enabled channel reloads itself and pulses scan_wrap every dwell+1 samples.
  - If ch_mask[cur] is cleared mid-dwell, advance to the next enabled channel on the next cycle (cnt=0, no transfer that cycle). Apply the wrap rule, scan_wrap included.
  - ch_mask going to 0 in RUN: return to IDLE next cycle, active=0.
  - dwell is sampled when a channel is entered; changes take effect at the next channel boundary.
- Mode change (either direction):
  - cnt=0, state=IDLE next cycle, cur re-evaluated from sel or mask.
  - A held output sample is not discarded.
- Width rule:
  - cnt is DWELL_W bits and the compare is exact; dwell = 2^DWELL_W-1 gives 2^DWELL_W samples per channel with no overflow.
- Reset mid-operation: all state returns to reset values on the next edge, and any pending output sample is dropped.

Test Plan:
- Reset/fixed mode: rst 2 cycles, then mode=0, sel=2, in_valid=4'b1111, channel i data = 16'hA000+i, out_ready=1 -> out_valid=0 during reset; from the cycle after the first transfer, out_data=16'hA002 and out_ch=2 every cycle, in_ready=4'b0100.
- Backpressure: fixed sel=1, out_ready low for 3 cycles -> out_data held stable, in_ready=0 during the stall, no samples lost or duplicated; the sample sequence resumes in order when out_ready returns to 1.
- Scan order/dwell: mode=1, ch_mask=4'b1011, dwell=1, all valid -> out_ch sequence 0,0,1,1,3,3,0,0...; scan_wrap pulses once per sequence, one cycle after the second channel-3 sample.
- Mask edge cases: ch_mask=0 -> no output, in_ready=0. ch_mask=4'b0100, dwell=0 -> every sample is channel 2 and scan_wrap pulses every cycle. Clear ch_mask[cur] mid-dwell -> next enabled channel is selected on the next cycle, with no extra sample from the disabled channel.
- Illegal select: NCH=3, SELW=2, mode=0, sel=3 -> in_ready=0 and out_valid stays 0.
- Mid-operation events: toggle mode during a dwell -> cnt restarts and the held output is preserved. Assert rst mid-scan -> out_valid=0, cur=0, scan restarts from the lowest enabled channel.
